// File: rtl/opb_register_bank_ppc2simulink_pkg.sv
// Shared types and helpers for the OPB PPC->Simulink register bank.
// Build option: OPB_REGBANK_SHADOW_COMMIT_EN (see top level).
package opb_regbank_pkg;

  localparam int unsigned OPB_DW  = 32;
  localparam int unsigned OPB_BEW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } opb_state_e;

  // Big-endian merge: be[0] and word[0:7] are the most significant byte.
  function automatic logic [0:OPB_DW-1] be_merge(input logic [0:OPB_DW-1]  old_w,
                                                 input logic [0:OPB_DW-1]  new_w,
                                                 input logic [0:OPB_BEW-1] be);
    logic [0:OPB_DW-1] res;
    res = old_w;
    for (int k = 0; k < OPB_BEW; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

  function automatic logic [OPB_DW-1:0] opb2le(input logic [0:OPB_DW-1] w);
    logic [OPB_DW-1:0] res;
    for (int i = 0; i < OPB_DW; i++) begin
      res[OPB_DW-1-i] = w[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side signal bundle for the register bank; OPB bit 0 is the MSB.
interface opb_register_bank_ppc2simulink_if;

  logic [0:31]                          OPB_ABus;
  logic [0:opb_regbank_pkg::OPB_BEW-1]  OPB_BE;
  logic [0:opb_regbank_pkg::OPB_DW-1]   OPB_DBus;
  logic                                 OPB_RNW;
  logic                                 OPB_select;
  logic                                 OPB_seqAddr;

  logic [0:opb_regbank_pkg::OPB_DW-1]   Sl_DBus;
  logic                                 Sl_errAck;
  logic                                 Sl_retry;
  logic                                 Sl_toutSup;
  logic                                 Sl_xferAck;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

endinterface

// File: rtl/opb_register_bank_ppc2simulink_slot.sv
// One PPC-writable register with byte-enable merge and update strobe.
// With OPB_REGBANK_SHADOW_COMMIT_EN, writes land in a shadow copied out on commit.
module opb_regbank_slot
  import opb_regbank_pkg::*;
#(
  parameter logic [OPB_DW-1:0] INIT_VALUE = '0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wr_en,
  input  logic [0:OPB_DW-1]   i_wr_data,
  input  logic [0:OPB_BEW-1]  i_wr_be,
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
  input  logic                i_commit,
`endif
  output logic [OPB_DW-1:0]   o_data,
  output logic                o_update,
  output logic [0:OPB_DW-1]   o_rd_data
);

  logic [0:OPB_DW-1] r_data;
  logic              r_update;

`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
  logic [0:OPB_DW-1] r_shadow;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= INIT_VALUE;
      r_data   <= INIT_VALUE;
      r_update <= 1'b0;
    end else begin
      r_update <= i_commit;
      if (i_wr_en)  r_shadow <= be_merge(r_shadow, i_wr_data, i_wr_be);
      if (i_commit) r_data   <= r_shadow;
    end
  end

  assign o_rd_data = r_shadow;
`else
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data   <= INIT_VALUE;
      r_update <= 1'b0;
    end else begin
      // An all-zero byte enable still counts as a write and still strobes.
      r_update <= i_wr_en;
      if (i_wr_en) r_data <= be_merge(r_data, i_wr_data, i_wr_be);
    end
  end

  assign o_rd_data = r_data;
`endif

  assign o_data   = opb2le(r_data);
  assign o_update = r_update;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave bank of N_REGS PPC->Simulink registers with readback and update strobes.
// Build option: define OPB_REGBANK_SHADOW_COMMIT_EN for shadow registers plus a COMMIT word.
module opb_register_bank_ppc2simulink
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100B000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100B0FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex6",
  parameter int unsigned N_REGS       = 4,
  parameter logic [31:0] INIT_VALUE   = 32'h0
) (
  input  logic                             OPB_Clk,
  input  logic                             OPB_Rst_n,
  opb_register_bank_ppc2simulink_if.slave  opb,
  output logic [N_REGS*C_OPB_DWIDTH-1:0]   user_data_out,
  output logic [N_REGS-1:0]                user_update
);

  localparam int unsigned IdxW = C_OPB_AWIDTH - 2;

  opb_state_e              r_state;
  opb_state_e              w_state_next;
  logic [C_OPB_AWIDTH-1:0] w_addr;
  logic [C_OPB_AWIDTH-1:0] w_off;
  logic [IdxW-1:0]         w_idx;
  logic                    w_hit;
  logic                    w_wr;
  logic [0:OPB_DW-1]       w_rd_word;
  logic [0:OPB_DW-1]       r_dbus;
  logic [0:OPB_DW-1]       w_slot_rd  [N_REGS];
  logic [OPB_DW-1:0]       w_slot_out [N_REGS];
  logic [N_REGS-1:0]       w_slot_wr;
  logic                    w_unused;

  assign w_addr = C_OPB_AWIDTH'(opb.OPB_ABus);
  assign w_off  = w_addr - C_OPB_AWIDTH'(C_BASEADDR);
  assign w_idx  = w_off[C_OPB_AWIDTH-1:2];
  assign w_hit  = opb.OPB_select && (r_state == IDLE) &&
                  (w_addr >= C_OPB_AWIDTH'(C_BASEADDR)) &&
                  (w_addr <= C_OPB_AWIDTH'(C_HIGHADDR));
  assign w_wr   = w_hit && !opb.OPB_RNW;

  assign w_unused = ^{opb.OPB_seqAddr, w_off[1:0]};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_hit) w_state_next = ACK;
      ACK:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Reads are latched at the hit edge so data appears only alongside the ack.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_state <= IDLE;
      r_dbus  <= '0;
    end else begin
      r_state <= w_state_next;
      r_dbus  <= (w_hit && opb.OPB_RNW) ? w_rd_word : '0;
    end
  end

  // Unmatched indices (out of range, or COMMIT) read back as zero.
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (w_idx == IdxW'(i)) w_rd_word = w_slot_rd[i];
    end
  end

`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
  localparam logic [IdxW-1:0] CommitIdx = IdxW'(N_REGS);
  logic w_commit;
  assign w_commit = w_wr && (w_idx == CommitIdx);
`endif

  for (genvar i = 0; i < N_REGS; i++) begin : g_slot
    assign w_slot_wr[i] = w_wr && (w_idx == IdxW'(i));

    opb_regbank_slot #(
      .INIT_VALUE (INIT_VALUE)
    ) u_slot (
      .i_clk     (OPB_Clk),
      .i_rst_n   (OPB_Rst_n),
      .i_wr_en   (w_slot_wr[i]),
      .i_wr_data (opb.OPB_DBus),
      .i_wr_be   (opb.OPB_BE),
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
      .i_commit  (w_commit),
`endif
      .o_data    (w_slot_out[i]),
      .o_update  (user_update[i]),
      .o_rd_data (w_slot_rd[i])
    );

    assign user_data_out[C_OPB_DWIDTH*i +: C_OPB_DWIDTH] = w_slot_out[i];
  end

  assign opb.Sl_DBus    = r_dbus;
  assign opb.Sl_xferAck = (r_state == ACK);
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed, scoreboard-checked bench for opb_register_bank_ppc2simulink.
// Honours OPB_REGBANK_SHADOW_COMMIT_EN when it is defined for the build.
module tb_opb_register_bank_ppc2simulink;

  localparam int unsigned N    = 4;
  localparam logic [31:0] BASE = 32'h0100_B000;
  localparam logic [31:0] INIT = 32'hA5A5_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [N*32-1:0] user_data_out;
  logic [N-1:0]    user_update;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic [N-1:0] upd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_out    [N];
  logic [31:0] m_shadow [N];
  logic [31:0] last_rdata;
  logic [N-1:0] last_upd;

  opb_register_bank_ppc2simulink_if bus ();

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR (BASE),
    .C_HIGHADDR (32'h0100_B0FF),
    .N_REGS     (N),
    .INIT_VALUE (INIT)
  ) u_dut (
    .OPB_Clk       (clk),
    .OPB_Rst_n     (rst_n),
    .opb           (bus),
    .user_data_out (user_data_out),
    .user_update   (user_update)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) begin
      if (be[3-k]) r[31-8*k -: 8] = new_w[31-8*k -: 8];
    end
    return r;
  endfunction

  function automatic logic [N*32-1:0] model_vec();
    logic [N*32-1:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = m_out[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_out[i]    = INIT;
      m_shadow[i] = INIT;
    end
  endtask

  // One OPB transfer: model the expectation, push it, drive, then pop on the ack.
  task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] data,
                      input logic [3:0] be, input string tag);
    exp_t e;
    int   idx;
    int   n;
    idx     = int'((addr - BASE) >> 2);
    e.tag   = tag;
    e.rdata = '0;
    e.upd   = '0;
    if (rnw) begin
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
      if (idx < N) e.rdata = m_shadow[idx];
`else
      if (idx < N) e.rdata = m_out[idx];
`endif
    end else begin
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
      if (idx < N) m_shadow[idx] = merge(m_shadow[idx], data, be);
      else if (idx == N) begin
        for (int i = 0; i < N; i++) m_out[i] = m_shadow[i];
        e.upd = '1;
      end
`else
      if (idx < N) begin
        m_out[idx] = merge(m_out[idx], data, be);
        e.upd[idx] = 1'b1;
      end
`endif
    end
    sb.push_back(e);

    @(negedge clk);
    bus.OPB_ABus   = addr;
    bus.OPB_RNW    = rnw;
    bus.OPB_DBus   = data;
    bus.OPB_BE     = be;
    bus.OPB_select = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.Sl_xferAck !== 1'b1 && n < 8);
    check({tag, " ack latency"}, 128'(n), 128'(1));

    e          = sb.pop_front();
    last_rdata = bus.Sl_DBus;
    last_upd   = user_update;
    check({e.tag, " rdata"}, 128'(bus.Sl_DBus), 128'(e.rdata));
    check({e.tag, " update"}, 128'(user_update), 128'(e.upd));
    check({e.tag, " outputs"}, 128'(user_data_out), 128'(model_vec()));
    bus.OPB_select = 1'b0;

    @(negedge clk);
    check({e.tag, " ack single"}, 128'(bus.Sl_xferAck), 128'(0));
    check({e.tag, " idle dbus"}, 128'(bus.Sl_DBus), 128'(0));
    check({e.tag, " update single"}, 128'(user_update), 128'(0));
  endtask

  initial begin
    bus.OPB_ABus    = '0;
    bus.OPB_BE      = '0;
    bus.OPB_DBus    = '0;
    bus.OPB_RNW     = 1'b0;
    bus.OPB_select  = 1'b0;
    bus.OPB_seqAddr = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset ack", 128'(bus.Sl_xferAck), 128'(0));
    check("reset dbus", 128'(bus.Sl_DBus), 128'(0));
    check("reset outputs", 128'(user_data_out), {4{INIT}});
    check("reset update", 128'(user_update), 128'(0));
    check("reset errack", 128'({bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Full word write and readback.
    xfer(BASE + 32'h8, 1'b0, 32'hDEAD_BEEF, 4'hF, "full write");
`ifndef OPB_REGBANK_SHADOW_COMMIT_EN
    check("full word2", 128'(user_data_out[95:64]), 128'(32'hDEAD_BEEF));
    check("full strobe", 128'(last_upd), 128'(4'b0100));
`endif
    xfer(BASE + 32'h8, 1'b1, 32'h0, 4'hF, "full read");
    check("full readback", 128'(last_rdata), 128'(32'hDEAD_BEEF));

    // Byte-enable merge.
    xfer(BASE + 32'h4, 1'b0, 32'h1122_3344, 4'hF, "merge seed");
    xfer(BASE + 32'h4, 1'b0, 32'hAABB_CCDD, 4'b1001, "merge write");
    xfer(BASE + 32'h4, 1'b1, 32'h0, 4'hF, "merge read");
    check("merge value", 128'(last_rdata), 128'(32'hAA22_33DD));

    // Zero byte enables: acked and strobed, data unchanged.
    xfer(BASE + 32'h4, 1'b0, 32'hFFFF_FFFF, 4'b0000, "be zero");
    xfer(BASE + 32'h4, 1'b1, 32'h0, 4'hF, "be zero read");
    check("be zero value", 128'(last_rdata), 128'(32'hAA22_33DD));

    // Out of range.
    xfer(BASE + 32'h40, 1'b0, 32'hFFFF_FFFF, 4'hF, "oor write");
    check("oor strobe", 128'(last_upd), 128'(0));
    xfer(BASE + 32'h40, 1'b1, 32'h0, 4'hF, "oor read");
    check("oor rdata", 128'(last_rdata), 128'(0));
`ifndef OPB_REGBANK_SHADOW_COMMIT_EN
    xfer(BASE + 32'h10, 1'b0, 32'h5555_5555, 4'hF, "word n write");
    check("word n strobe", 128'(last_upd), 128'(0));
`endif

    // Back-to-back: select held for six cycles.
    @(negedge clk);
    bus.OPB_ABus   = BASE + 32'hC;
    bus.OPB_RNW    = 1'b0;
    bus.OPB_DBus   = 32'h1234_5678;
    bus.OPB_BE     = 4'hF;
    bus.OPB_select = 1'b1;
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
    m_shadow[3] = 32'h1234_5678;
`else
    m_out[3] = 32'h1234_5678;
`endif
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("b2b ack %0d", i), 128'(bus.Sl_xferAck), 128'((i % 2) == 0));
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
      check($sformatf("b2b update %0d", i), 128'(user_update), 128'(0));
`else
      check($sformatf("b2b update %0d", i), 128'(user_update),
            ((i % 2) == 0) ? 128'(4'b1000) : 128'(0));
`endif
    end
    bus.OPB_select = 1'b0;
    check("b2b outputs", 128'(user_data_out), 128'(model_vec()));

`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
    // Shadow staging and commit.
    for (int i = 0; i < N; i++) begin
      xfer(BASE + 32'(4 * i), 1'b0, 32'(i + 1), 4'hF, $sformatf("shadow write %0d", i));
    end
    for (int i = 0; i < N; i++) begin
      xfer(BASE + 32'(4 * i), 1'b1, 32'h0, 4'hF, $sformatf("shadow read %0d", i));
      check($sformatf("shadow value %0d", i), 128'(last_rdata), 128'(i + 1));
    end
    xfer(BASE + 32'h10, 1'b0, 32'h0, 4'hF, "commit");
    check("commit strobe", 128'(last_upd), 128'(4'hF));
    check("commit outputs", 128'(user_data_out),
          128'({32'd4, 32'd3, 32'd2, 32'd1}));
    xfer(BASE + 32'h10, 1'b1, 32'h0, 4'hF, "commit read");
    check("commit rdata", 128'(last_rdata), 128'(0));
`endif

    // Reset asserted during an ACK cycle.
    @(negedge clk);
    bus.OPB_ABus   = BASE;
    bus.OPB_RNW    = 1'b0;
    bus.OPB_DBus   = 32'hCAFE_F00D;
    bus.OPB_BE     = 4'hF;
    bus.OPB_select = 1'b1;
    @(posedge clk);
    #1;
    check("pre-reset ack", 128'(bus.Sl_xferAck), 128'(1));
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst ack", 128'(bus.Sl_xferAck), 128'(0));
    check("midrst dbus", 128'(bus.Sl_DBus), 128'(0));
    check("midrst outputs", 128'(user_data_out), {4{INIT}});
    check("midrst update", 128'(user_update), 128'(0));
    bus.OPB_select = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < N; i++) begin
      xfer(BASE + 32'(4 * i), 1'b1, 32'h0, 4'hF, $sformatf("post reset read %0d", i));
      check($sformatf("post reset value %0d", i), 128'(last_rdata), 128'(INIT));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
